// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM. Controls are registered from the next state
// so they change only on clk edges; pcen and irwrite also look at zero/mem_ready.
module mc_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_JAL   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic       signext,
  output logic       shiftl16,
  output logic       link,
  output logic       illegal,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR  = 4'd5, S_RTEX   = 4'd6, S_RTWB  = 4'd7,
    S_BR    = 4'd8, S_IEX    = 4'd9, S_IWB    = 4'd10, S_JMP  = 4'd11,
    S_JAL   = 4'd12, S_ERR   = 4'd15
  } state_t;

  typedef struct packed {
    logic       memread, iord, memwrite, memtoreg, regdst, regwrite;
    logic       alusrca, signext, shiftl16, link, illegal, pcwrite, branch;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol;
  } ctl_t;

  localparam logic [5:0] OP_RT = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ADDIU = 6'b001001, OP_ORI = 6'b001101, OP_LUI = 6'b001111,
                         OP_J = 6'b000010, OP_JAL = 6'b000011;

  function automatic logic rt_ok(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b101010, 6'b101011: rt_ok = 1'b1;
      default:                                    rt_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] rt_alu(input logic [5:0] f);
    case (f)
      6'b100010, 6'b100011: rt_alu = 4'b1100;
      6'b100100:            rt_alu = 4'b0000;
      6'b100101:            rt_alu = 4'b0010;
      6'b101010:            rt_alu = 4'b1110;
      6'b101011:            rt_alu = 4'b1111;
      default:              rt_alu = 4'b0100;
    endcase
  endfunction

  // op/funct only matter when entering RTEX/IEX, i.e. sampled in DECODE
  function automatic ctl_t ctl_of(input state_t s, input logic [5:0] o, input logic [5:0] f);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; c.alucontrol = 4'b0100; end
      S_DECODE: begin c.alusrcb = 2'b11; c.alucontrol = 4'b0100; end
      S_MEMADR: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.signext = 1'b1; c.alucontrol = 4'b0100;
      end
      S_MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      S_RTEX:   begin c.alusrca = 1'b1; c.alucontrol = rt_alu(f); end
      S_RTWB:   begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_BR:     begin
        c.alusrca = 1'b1; c.alucontrol = 4'b1100; c.branch = 1'b1; c.pcsrc = 2'b01;
      end
      S_IEX:    begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10;
        case (o)
          OP_ORI:  c.alucontrol = 4'b0010;
          OP_LUI:  begin c.shiftl16 = 1'b1; c.alucontrol = 4'b0100; end
          default: begin c.signext = 1'b1; c.alucontrol = 4'b0100; end
        endcase
      end
      S_IWB:    c.regwrite = 1'b1;
      S_JMP:    begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
      S_JAL:    begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; c.regwrite = 1'b1; c.link = 1'b1; end
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  state_t st, nxt;
  ctl_t   c_q;
  logic   rdy, is_sw, bne;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    nxt = st;
    case (st)
      S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                      nxt = S_MEMADR;
          OP_RT:                             nxt = S_RTEX;
          OP_BEQ, OP_BNE:                    nxt = S_BR;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: nxt = S_IEX;
          OP_J:                              nxt = S_JMP;
          OP_JAL:                            nxt = SUPPORT_JAL ? S_JAL : S_ERR;
          default:                           nxt = S_ERR;
        endcase
      end
      S_MEMADR: nxt = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
      S_RTEX:   nxt = rt_ok(funct) ? S_RTWB : S_ERR;
      S_IEX:    nxt = S_IWB;
      S_MEMWB, S_RTWB, S_BR, S_IWB, S_JMP, S_JAL: nxt = S_FETCH;
      default:  nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= S_FETCH;
      c_q   <= ctl_of(S_FETCH, 6'd0, 6'd0);
      is_sw <= 1'b0;
      bne   <= 1'b0;
    end else begin
      st  <= nxt;
      c_q <= ctl_of(nxt, op, funct);
      if (st == S_DECODE) begin
        is_sw <= (op == OP_SW);
        bne   <= op[0];
      end
    end
  end

  assign irwrite    = reset & (st == S_FETCH) & rdy;
  assign pcen       = reset & (irwrite | c_q.pcwrite | (c_q.branch & (zero ^ bne)));
  assign state      = st;
  assign iord       = c_q.iord;
  assign memread    = c_q.memread;
  assign memwrite   = c_q.memwrite;
  assign memtoreg   = c_q.memtoreg;
  assign regdst     = c_q.regdst;
  assign regwrite   = c_q.regwrite;
  assign alusrca    = c_q.alusrca;
  assign signext    = c_q.signext;
  assign shiftl16   = c_q.shiftl16;
  assign link       = c_q.link;
  assign illegal    = c_q.illegal;
  assign alusrcb    = c_q.alusrcb;
  assign pcsrc      = c_q.pcsrc;
  assign alucontrol = c_q.alucontrol;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: default instance plus a no-JAL, no-handshake instance.
module tb_mc_controller;
  logic clk = 1'b0, reset = 1'b0, reset_nj = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic pcen, iord, irwrite, memread, memwrite, memtoreg, regdst, regwrite;
  logic alusrca, signext, shiftl16, link, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol, state;
  logic n_pcen, n_iord, n_irwrite, n_memread, n_memwrite, n_memtoreg, n_regdst, n_regwrite;
  logic n_alusrca, n_signext, n_shiftl16, n_link, n_illegal;
  logic [1:0] n_alusrcb, n_pcsrc;
  logic [3:0] n_alucontrol, n_state;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .irwrite(irwrite), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .signext(signext), .shiftl16(shiftl16), .link(link), .illegal(illegal),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state));

  mc_controller #(.MEM_HANDSHAKE(1'b0), .SUPPORT_JAL(1'b0)) dut_nj (
    .clk(clk), .reset(reset_nj), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(n_pcen), .iord(n_iord), .irwrite(n_irwrite), .memread(n_memread),
    .memwrite(n_memwrite), .memtoreg(n_memtoreg), .regdst(n_regdst), .regwrite(n_regwrite),
    .alusrca(n_alusrca), .signext(n_signext), .shiftl16(n_shiftl16), .link(n_link),
    .illegal(n_illegal), .alusrcb(n_alusrcb), .pcsrc(n_pcsrc), .alucontrol(n_alucontrol),
    .state(n_state));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {logic [5:0] op; logic [3:0] alu; logic sx; logic sh;} ivec_t;
  ivec_t iv[3];

  initial begin
    iv[0] = '{6'b001000, 4'b0100, 1'b1, 1'b0};
    iv[1] = '{6'b001101, 4'b0010, 1'b0, 1'b0};
    iv[2] = '{6'b001111, 4'b0100, 1'b0, 1'b1};

    // reset state
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_memread", memread, 1);
    chk("rst_alusrcb", alusrcb, 2'b01);
    chk("rst_alu", alucontrol, 4'b0100);
    chk("rst_irwrite", irwrite, 0);
    chk("rst_pcen", pcen, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_regwrite", regwrite, 0);

    // LW, op changed after DECODE must be ignored
    reset = 1'b1; op = 6'b100011; mem_ready = 1'b1;
    #1;
    chk("fetch_irwrite", irwrite, 1);
    chk("fetch_pcen", pcen, 1);
    step(); chk("lw_s1", state, 1); chk("dec_alusrcb", alusrcb, 2'b11);
    step(); chk("lw_s2", state, 2); chk("madr_srcb", alusrcb, 2'b10);
    chk("madr_sx", signext, 1); chk("madr_srca", alusrca, 1);
    op = 6'b101011;
    step(); chk("lw_s3", state, 3); chk("mrd_iord", iord, 1); chk("mrd_rd", memread, 1);
    chk("mrd_rw", regwrite, 0);
    step(); chk("lw_s4", state, 4); chk("mwb_rw", regwrite, 1); chk("mwb_m2r", memtoreg, 1);
    step(); chk("lw_s0", state, 0); chk("lw_end_rw", regwrite, 0);

    // FETCH holds without mem_ready
    mem_ready = 1'b0; #1;
    chk("hold_irw", irwrite, 0); chk("hold_pcen", pcen, 0);
    step(); chk("hold_state", state, 0);

    // SW with three wait cycles
    mem_ready = 1'b1; op = 6'b101011;
    step(); step(); chk("sw_s2", state, 2);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("sw_wr_state", state, 5);
      chk("sw_memwrite", memwrite, 1);
      chk("sw_memread", memread, 0);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    chk("sw_back", state, 0); chk("sw_wr_off", memwrite, 0);

    // R-type slt
    op = 6'b000000; funct = 6'b101010;
    step(); step();
    chk("rt_state", state, 6); chk("rt_alu", alucontrol, 4'b1110);
    chk("rt_srca", alusrca, 1); chk("rt_srcb", alusrcb, 2'b00);
    step(); chk("rtwb_state", state, 7); chk("rtwb_rw", regwrite, 1); chk("rtwb_dst", regdst, 1);
    step(); chk("rt_back", state, 0);

    // BNE taken/not taken
    op = 6'b000101; zero = 1'b0;
    step(); step();
    chk("bne_state", state, 8); chk("bne_pcsrc", pcsrc, 2'b01);
    chk("bne_alu", alucontrol, 4'b1100); chk("bne_pcen_z0", pcen, 1);
    zero = 1'b1; #1; chk("bne_pcen_z1", pcen, 0);
    step(); chk("bne_back", state, 0);
    // BEQ taken on zero=1
    op = 6'b000100;
    step(); step(); chk("beq_pcen_z1", pcen, 1);
    step(); zero = 1'b0;

    // I-type table
    for (int k = 0; k < 3; k++) begin
      op = iv[k].op;
      step(); step();
      chk("iex_state", state, 9);
      chk("iex_alu", alucontrol, iv[k].alu);
      chk("iex_sx", signext, iv[k].sx);
      chk("iex_shl", shiftl16, iv[k].sh);
      step(); chk("iwb_rw", regwrite, 1); chk("iwb_dst", regdst, 0);
      step(); chk("i_back", state, 0);
    end

    // JAL on both instances; no-handshake instance ignores mem_ready
    reset_nj = 1'b1; mem_ready = 1'b0; op = 6'b000011;
    step(); chk("nj_noshake", n_state, 1); chk("jal_hold", state, 0);
    mem_ready = 1'b1;
    step(); chk("nj_err", n_state, 15); chk("nj_illegal", n_illegal, 1); chk("jal_dec", state, 1);
    step(); chk("jal_state", state, 12); chk("jal_rw", regwrite, 1); chk("jal_link", link, 1);
    chk("jal_pcsrc", pcsrc, 2'b10); chk("jal_pcen", pcen, 1); chk("nj_stay", n_state, 15);
    step(); chk("jal_back", state, 0);

    // bad funct in RTEX
    op = 6'b000000; funct = 6'b111111;
    step(); step(); chk("badf_rtex", state, 6);
    step(); chk("badf_err", state, 15); chk("badf_ill", illegal, 1);
    reset = 1'b0; #2;
    chk("err_rst_state", state, 0); chk("err_rst_ill", illegal, 0);
    step(); chk("rst_held", state, 0); chk("rst_irw", irwrite, 0);
    reset = 1'b1;

    // illegal op held in ERR
    op = 6'b111111;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      chk("ill_state", state, 15); chk("ill_flag", illegal, 1);
      chk("ill_rw", regwrite, 0); chk("ill_rd", memread, 0);
      step();
    end
    reset = 1'b0; #2;
    chk("ill_rst_state", state, 0); chk("ill_rst_flag", illegal, 0); chk("ill_rst_rd", memread, 1);
    reset = 1'b1;

    // reset mid MEMRD wait
    op = 6'b100011; mem_ready = 1'b1;
    step(); step(); chk("mrd_pre", state, 2);
    mem_ready = 1'b0;
    step(); step(); chk("mrd_wait", state, 3); chk("mrd_wait_rd", memread, 1);
    #3; mem_ready = 1'b1; reset = 1'b0; #1;
    chk("mrd_abort", state, 0); chk("mrd_iord", iord, 0); chk("mrd_rd0", memread, 1);
    chk("mrd_rw0", regwrite, 0); chk("mrd_irw0", irwrite, 0);
    reset = 1'b1;
    step(); chk("rel_adv", state, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
